dsp_mac_pipe: RTL and testbench
===============================

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 SHALL have parameter A_W, 18, signed width of A.
REQ-002 SHALL have parameter B_W, 18, signed width of B, D and BCOUT.
REQ-003 SHALL have parameter P_W, 48, signed width of C, PCIN, P and PCOUT; P_W >= A_W+B_W+1 is checked at elaboration.
REQ-004 SHALL have parameter SAT, 0, where 1 selects saturation and 0 selects wrap-around.
REQ-005 SHALL have ports: clk in 1, the single clock; all flops update on the rising edge.
REQ-006 SHALL have port RSTN in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: CE in 1 global clock enable; IN_VALID in 1 sample valid; A in A_W; B in B_W; D in B_W; C in P_W; PCIN in P_W cascade input; CARRYIN in 1; OPMODE in 8.
REQ-008 SHALL have ports: OUT_VALID out 1; P out P_W; PCOUT out P_W (equal to P); M out A_W+B_W+1 (product register); BCOUT out B_W (stage-1 B register); CARRYOUT out 1; OVF out 1.

Function
REQ-009 OPMODE fields: [0] pre-adder enable; [1] pre-adder subtract (D-B, else D+B); [3:2] Z mux (00 zero, 01 C, 10 PCIN, 11 P feedback); [4] post-subtract (Z-M-cin, else Z+M+cin); [5] carry-in enable (cin = CARRYIN & OPMODE[5]); [7:6] reserved and ignored.
REQ-010 Stage 1 SHALL register A, B, D, C, PCIN, CARRYIN, OPMODE and IN_VALID together when CE=1.
REQ-011 Stage 2 SHALL register M = A1 * pre, where pre = D1±B1 on B_W+1 bits when OPMODE1[0]=1, else sign-extended B1; signed two's complement; it also forwards the valid and control bits.
REQ-012 Stage 3 SHALL compute Z ± sign-extended M ± cin on P_W+1 bits and SHALL register P, CARRYOUT (bit P_W of the unsigned sum) and OVF (signed overflow) only when the stage-3 valid bit is 1 and CE=1; otherwise P, CARRYOUT and OVF hold.
REQ-013 Latency SHALL be 3 enabled cycles: a sample accepted at edge n drives OUT_VALID=1 after edge n+2. OUT_VALID is the registered stage-3 valid.
REQ-014 Z=P feedback SHALL use the current P register, so back-to-back valid samples accumulate every cycle without stalls.
REQ-015 IN_VALID=0 SHALL insert a bubble: the pipe advances, OUT_VALID=0 at the bubble's output slot, and P holds.
REQ-016 CE=0 SHALL freeze every register, including the valid bits; outputs hold and latency stretches by the number of CE=0 cycles.
REQ-017 SAT=1: on overflow, P SHALL clamp to +2^(P_W-1)-1 or -2^(P_W-1) by the sign of the true result; SAT=0: P wraps. In both modes OVF=1 for that sample only.
REQ-018 OPMODE[7:6] SHALL have no effect on any output.

Reset
REQ-019 RSTN=0 SHALL asynchronously clear all pipeline registers; P, PCOUT, M, BCOUT, CARRYOUT, OVF and OUT_VALID read 0.
REQ-020 Reset mid-operation SHALL discard in-flight samples; no OUT_VALID pulse for them after release.
REQ-021 After RSTN rises, the first valid sample SHALL produce its result 3 enabled cycles later.

Structure
REQ-022 OPMODE bit positions, Z-mux encodings and the saturation limit function SHALL live in shared package dsp_pkg.
REQ-023 Stage 3 (Z mux, add/sub, carry, saturation, P register) SHALL be a sub-module named dsp_post_acc; stages 1-2 are inline.

Verification
REQ-024 A=1, B=1, D=1, C=1, CARRYIN=1, OPMODE=0x25 (pre-add, Z=C, cin) -> P=4, CARRYOUT=0, OUT_VALID=1 three cycles after accept.
REQ-025 A=3, B=2, D=5, OPMODE=0x03 (D-B, Z=0) -> M=9, P=9; then OPMODE=0x13 (post-subtract, Z=0) -> P=-9.
REQ-026 Accumulate: first sample A=2, B=3, OPMODE=0x00 -> P=6; then three samples with OPMODE=0x0C -> P=12, 18, 24; a bubble inserted between them keeps P=18 with OUT_VALID=0.
REQ-027 SAT=1, C=2^47-1, A=1, B=1, OPMODE=0x04 -> P=2^47-1, OVF=1; with SAT=0 -> P=-2^47, OVF=1.
REQ-028 CE=0 for 2 cycles with 3 samples in flight -> all outputs frozen; results appear 2 cycles late, in order, none lost.
REQ-029 RSTN pulsed low mid-accumulation -> P=0 and OUT_VALID=0 immediately; no stale OUT_VALID after release; next sample valid 3 cycles later.

Source files
------------

// File: rtl/dsp_pkg.sv
// dsp_pkg -- shared definitions for the DSP multiply-accumulate slice.
//   OPMODE bit positions, Z-mux encodings and the saturation limit helper.
package dsp_pkg;

  // OPMODE bit positions; bits [7:6] are reserved and never decoded.
  localparam int OP_PRE_EN   = 0;  // pre-adder enable
  localparam int OP_PRE_SUB  = 1;  // pre-adder computes D-B instead of D+B
  localparam int OP_Z_LO     = 2;  // Z mux select, low bit
  localparam int OP_Z_HI     = 3;  // Z mux select, high bit
  localparam int OP_POST_SUB = 4;  // post-adder computes Z-M-cin
  localparam int OP_CIN_EN   = 5;  // carry-in enable

  // Z mux source encodings (OPMODE[3:2]).
  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_C    = 2'b01,
    Z_PCIN = 2'b10,
    Z_P    = 2'b11
  } zmux_e;

  // Widest P supported by the saturation helper.
  localparam int SAT_MAX_W = 128;

  // Saturation limit for a w-bit signed result: -2^(w-1) when neg, else
  // 2^(w-1)-1. Bits at and above w are don't-care for the caller.
  function automatic logic [SAT_MAX_W-1:0] sat_limit(input logic neg, input int w);
    logic [SAT_MAX_W-1:0] v;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < w - 1) begin
        v[i] = ~neg;
      end else begin
        v[i] = neg;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/dsp_post_acc.sv
// dsp_post_acc -- stage 3 of the MAC pipe: Z mux, post add/subtract with
// carry-in, carry-out and signed overflow detection, optional saturation,
// and the P register.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_ce              global clock enable (freezes everything when 0)
//   i_valid           stage-2 valid; P/CARRYOUT/OVF only load when set
//   i_zsel            Z mux select (zmux_e encoding)
//   i_sub             1: Z-M-cin, 0: Z+M+cin
//   i_cin             effective carry-in (already gated by its enable)
//   i_c, i_pcin       Z sources C and cascade input (stage-2 aligned)
//   i_m               signed product from stage 2
//   o_p, o_carry      registered result and carry-out
//   o_ovf, o_valid    registered overflow flag and output valid
module dsp_post_acc
  import dsp_pkg::*;
#(
  parameter int P_W = 48,
  parameter int M_W = 37,
  parameter int SAT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ce,
  input  logic                  i_valid,
  input  logic [1:0]            i_zsel,
  input  logic                  i_sub,
  input  logic                  i_cin,
  input  logic [P_W-1:0]        i_c,
  input  logic [P_W-1:0]        i_pcin,
  input  logic signed [M_W-1:0] i_m,
  output logic [P_W-1:0]        o_p,
  output logic                  o_carry,
  output logic                  o_ovf,
  output logic                  o_valid
);

  logic [P_W-1:0]        r_p;
  logic                  r_carry;
  logic                  r_ovf;
  logic                  r_valid;

  logic [P_W-1:0]        w_z;
  logic signed [P_W-1:0] w_m_ext;
  logic [P_W:0]          w_z_sx;
  logic [P_W:0]          w_m_sx;
  logic [P_W:0]          w_z_zx;
  logic [P_W:0]          w_m_zx;
  logic [P_W:0]          w_cin_x;
  logic [P_W:0]          w_ssum;
  logic [P_W:0]          w_usum;
  logic                  w_ovf;
  logic [SAT_MAX_W-1:0]  w_lim_full;
  logic [P_W-1:0]        w_p_next;

  assign w_m_ext = P_W'(i_m);

  // Sign-extended operands give the true signed result; zero-extended ones
  // give the unsigned sum whose top bit is the carry-out.
  assign w_z_sx  = {w_z[P_W-1], w_z};
  assign w_m_sx  = {w_m_ext[P_W-1], w_m_ext};
  assign w_z_zx  = {1'b0, w_z};
  assign w_m_zx  = {1'b0, w_m_ext};
  assign w_cin_x = {{P_W{1'b0}}, i_cin};

  assign w_ssum = i_sub ? (w_z_sx - w_m_sx - w_cin_x) : (w_z_sx + w_m_sx + w_cin_x);
  assign w_usum = i_sub ? (w_z_zx - w_m_zx - w_cin_x) : (w_z_zx + w_m_zx + w_cin_x);

  // The P_W+1-bit signed sum cannot itself overflow, so a disagreement
  // between its top two bits means the P_W-bit result did.
  assign w_ovf      = w_ssum[P_W] ^ w_ssum[P_W-1];
  assign w_lim_full = sat_limit(w_ssum[P_W], P_W);

  // Z source selection; Z_P feeds back the live P register.
  always_comb begin
    w_z = {P_W{1'b0}};
    case (zmux_e'(i_zsel))
      Z_ZERO:  w_z = {P_W{1'b0}};
      Z_C:     w_z = i_c;
      Z_PCIN:  w_z = i_pcin;
      Z_P:     w_z = r_p;
      default: w_z = {P_W{1'b0}};
    endcase
  end

  // Next P value: clamp on overflow in saturating mode, otherwise wrap.
  always_comb begin
    w_p_next = w_ssum[P_W-1:0];
    if ((SAT != 0) && w_ovf) begin
      w_p_next = w_lim_full[P_W-1:0];
    end else begin
      w_p_next = w_ssum[P_W-1:0];
    end
  end

  // Stage-3 registers: valid follows CE; result only loads for valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p     <= {P_W{1'b0}};
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_ce) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_p     <= w_p_next;
        r_carry <= w_usum[P_W];
        r_ovf   <= w_ovf;
      end
    end
  end

  assign o_p     = r_p;
  assign o_carry = r_carry;
  assign o_ovf   = r_ovf;
  assign o_valid = r_valid;

endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe -- three-stage signed multiply-accumulate slice.
//   Stage 1 registers all inputs, stage 2 forms M = A * (D+/-B or B),
//   stage 3 (dsp_post_acc) forms P = Z +/- M +/- cin.
// Ports:
//   clk, RSTN               clock, async active-low reset
//   CE, IN_VALID            clock enable, input sample valid
//   A, B, D, C, PCIN        data inputs (signed)
//   CARRYIN, OPMODE         carry-in, operation select
//   OUT_VALID               result valid (3 enabled cycles after accept)
//   P, PCOUT                result and cascade copy
//   M                       product register
//   BCOUT                   stage-1 B register
//   CARRYOUT, OVF           carry-out and signed overflow of the last result
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int P_W = 48,
  parameter int SAT = 0
) (
  input  logic                   clk,
  input  logic                   RSTN,
  input  logic                   CE,
  input  logic                   IN_VALID,
  input  logic [A_W-1:0]         A,
  input  logic [B_W-1:0]         B,
  input  logic [B_W-1:0]         D,
  input  logic [P_W-1:0]         C,
  input  logic [P_W-1:0]         PCIN,
  input  logic                   CARRYIN,
  input  logic [7:0]             OPMODE,
  output logic                   OUT_VALID,
  output logic [P_W-1:0]         P,
  output logic [P_W-1:0]         PCOUT,
  output logic [A_W+B_W:0]       M,
  output logic [B_W-1:0]         BCOUT,
  output logic                   CARRYOUT,
  output logic                   OVF
);

  localparam int M_W = A_W + B_W + 1;

  if (P_W < M_W) begin : g_width_check
    $error("dsp_mac_pipe: P_W must be at least A_W+B_W+1");
  end

  // Stage 1
  logic signed [A_W-1:0] r_a1;
  logic signed [B_W-1:0] r_b1;
  logic signed [B_W-1:0] r_d1;
  logic [P_W-1:0]        r_c1;
  logic [P_W-1:0]        r_pcin1;
  logic                  r_cin1;
  logic [5:0]            r_op1;
  logic                  r_v1;

  // Stage 2
  logic signed [M_W-1:0] r_m2;
  logic [P_W-1:0]        r_c2;
  logic [P_W-1:0]        r_pcin2;
  logic                  r_cin2;
  logic [1:0]            r_zsel2;
  logic                  r_sub2;
  logic                  r_v2;

  logic signed [B_W:0]   w_d_x;
  logic signed [B_W:0]   w_b_x;
  logic signed [B_W:0]   w_pre;
  logic signed [M_W-1:0] w_a_m;
  logic signed [M_W-1:0] w_pre_m;
  logic signed [M_W-1:0] w_prod;

  // Stage 1: capture every input together; reserved OPMODE bits are dropped.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_a1    <= {A_W{1'b0}};
      r_b1    <= {B_W{1'b0}};
      r_d1    <= {B_W{1'b0}};
      r_c1    <= {P_W{1'b0}};
      r_pcin1 <= {P_W{1'b0}};
      r_cin1  <= 1'b0;
      r_op1   <= 6'b000000;
      r_v1    <= 1'b0;
    end else if (CE) begin
      r_a1    <= A;
      r_b1    <= B;
      r_d1    <= D;
      r_c1    <= C;
      r_pcin1 <= PCIN;
      r_cin1  <= CARRYIN;
      r_op1   <= OPMODE[5:0];
      r_v1    <= IN_VALID;
    end
  end

  assign w_d_x = (B_W+1)'(r_d1);
  assign w_b_x = (B_W+1)'(r_b1);

  // Pre-adder: D+/-B on B_W+1 bits so the sum never wraps, or plain B.
  always_comb begin
    w_pre = w_b_x;
    if (r_op1[OP_PRE_EN]) begin
      if (r_op1[OP_PRE_SUB]) begin
        w_pre = w_d_x - w_b_x;
      end else begin
        w_pre = w_d_x + w_b_x;
      end
    end else begin
      w_pre = w_b_x;
    end
  end

  assign w_a_m   = M_W'(r_a1);
  assign w_pre_m = M_W'(w_pre);
  assign w_prod  = w_a_m * w_pre_m;

  // Stage 2: product register plus the controls and Z sources stage 3 needs.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_m2    <= {M_W{1'b0}};
      r_c2    <= {P_W{1'b0}};
      r_pcin2 <= {P_W{1'b0}};
      r_cin2  <= 1'b0;
      r_zsel2 <= 2'b00;
      r_sub2  <= 1'b0;
      r_v2    <= 1'b0;
    end else if (CE) begin
      r_m2    <= w_prod;
      r_c2    <= r_c1;
      r_pcin2 <= r_pcin1;
      r_cin2  <= r_cin1 & r_op1[OP_CIN_EN];
      r_zsel2 <= r_op1[OP_Z_HI:OP_Z_LO];
      r_sub2  <= r_op1[OP_POST_SUB];
      r_v2    <= r_v1;
    end
  end

  logic [P_W-1:0] w_p;

  dsp_post_acc #(
    .P_W (P_W),
    .M_W (M_W),
    .SAT (SAT)
  ) u_post_acc (
    .clk     (clk),
    .rst_n   (RSTN),
    .i_ce    (CE),
    .i_valid (r_v2),
    .i_zsel  (r_zsel2),
    .i_sub   (r_sub2),
    .i_cin   (r_cin2),
    .i_c     (r_c2),
    .i_pcin  (r_pcin2),
    .i_m     (r_m2),
    .o_p     (w_p),
    .o_carry (CARRYOUT),
    .o_ovf   (OVF),
    .o_valid (OUT_VALID)
  );

  assign P     = w_p;
  assign PCOUT = w_p;
  assign M     = r_m2;
  assign BCOUT = r_b1;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe -- directed self-checking bench for dsp_mac_pipe.
//   u_dut runs in wrap mode, u_sat in saturating mode; both see the same
//   stimulus. Inputs change 1 time unit after a rising edge and outputs are
//   sampled at that same point.
module tb_dsp_mac_pipe;

  logic               clk = 1'b0;
  logic               RSTN;
  logic               CE;
  logic               IN_VALID;
  logic [17:0]        A;
  logic [17:0]        B;
  logic [17:0]        D;
  logic [47:0]        C;
  logic [47:0]        PCIN;
  logic               CARRYIN;
  logic [7:0]         OPMODE;

  logic               ov_w, ov_s;
  logic [47:0]        p_w, p_s, pc_w, pc_s;
  logic [36:0]        m_w, m_s;
  logic [17:0]        bc_w, bc_s;
  logic               co_w, co_s, ovf_w, ovf_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.A_W(18), .B_W(18), .P_W(48), .SAT(0)) u_dut (
    .clk(clk), .RSTN(RSTN), .CE(CE), .IN_VALID(IN_VALID),
    .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .OUT_VALID(ov_w), .P(p_w), .PCOUT(pc_w), .M(m_w), .BCOUT(bc_w),
    .CARRYOUT(co_w), .OVF(ovf_w)
  );

  dsp_mac_pipe #(.A_W(18), .B_W(18), .P_W(48), .SAT(1)) u_sat (
    .clk(clk), .RSTN(RSTN), .CE(CE), .IN_VALID(IN_VALID),
    .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .OUT_VALID(ov_s), .P(p_s), .PCOUT(pc_s), .M(m_s), .BCOUT(bc_s),
    .CARRYOUT(co_s), .OVF(ovf_s)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                      input logic [47:0] c, input logic cin, input logic [7:0] op);
    A = a; B = b; D = d; C = c; CARRYIN = cin; OPMODE = op; IN_VALID = 1'b1;
    tick();
  endtask

  task automatic idle();
    IN_VALID = 1'b0;
    tick();
  endtask

  initial begin
    RSTN = 1'b0; CE = 1'b1; IN_VALID = 1'b0;
    A = 18'd0; B = 18'd0; D = 18'd0; C = 48'd0; PCIN = 48'd0;
    CARRYIN = 1'b0; OPMODE = 8'h00;
    tick(); tick();

    // Reset state
    chk("rst_p",      p_w,   48'd0);
    chk("rst_pcout",  pc_w,  48'd0);
    chk("rst_m",      {11'd0, m_w}, 48'd0);
    chk("rst_bcout",  {30'd0, bc_w}, 48'd0);
    chk("rst_carry",  {47'd0, co_w}, 48'd0);
    chk("rst_ovf",    {47'd0, ovf_w}, 48'd0);
    chk("rst_valid",  {47'd0, ov_w}, 48'd0);
    RSTN = 1'b1;
    tick();

    // Pre-add, Z=C, carry-in: 1*(1+1) + 1 + 1 = 4
    send(18'd1, 18'd1, 18'd1, 48'd1, 1'b1, 8'h25);
    chk("t1_valid_e0", {47'd0, ov_w}, 48'd0);
    chk("t1_bcout",    {30'd0, bc_w}, 48'd1);
    idle();
    chk("t1_valid_e1", {47'd0, ov_w}, 48'd0);
    chk("t1_m",        {11'd0, m_w}, 48'd2);
    idle();
    chk("t1_valid_e2", {47'd0, ov_w}, 48'd1);
    chk("t1_p",        p_w,  48'd4);
    chk("t1_pcout",    pc_w, 48'd4);
    chk("t1_carry",    {47'd0, co_w}, 48'd0);
    chk("t1_sat_p",    p_s,  48'd4);
    idle();
    chk("t1_valid_drop", {47'd0, ov_w}, 48'd0);
    chk("t1_p_hold",     p_w, 48'd4);

    // Pre-subtract: 3*(5-2) = 9, then post-subtract from zero: -9
    C = 48'd0; CARRYIN = 1'b0;
    send(18'd3, 18'd2, 18'd5, 48'd0, 1'b0, 8'h03);
    send(18'd3, 18'd2, 18'd5, 48'd0, 1'b0, 8'h13);
    chk("t2_m", {11'd0, m_w}, 48'd9);
    idle();
    chk("t2_p_pos", p_w, 48'd9);
    idle();
    chk("t2_p_neg", p_w, 48'hFFFF_FFFF_FFF7);
    chk("t2_valid", {47'd0, ov_w}, 48'd1);
    chk("t2_ovf",   {47'd0, ovf_w}, 48'd0);

    // Accumulate 2*3 with Z=P feedback, bubble between third and fourth
    send(18'd2, 18'd3, 18'd0, 48'd0, 1'b0, 8'h00);
    send(18'd2, 18'd3, 18'd0, 48'd0, 1'b0, 8'h0C);
    send(18'd2, 18'd3, 18'd0, 48'd0, 1'b0, 8'h0C);
    chk("t3_p6", p_w, 48'd6);
    idle();
    chk("t3_p12", p_w, 48'd12);
    send(18'd2, 18'd3, 18'd0, 48'd0, 1'b0, 8'h0C);
    chk("t3_p18", p_w, 48'd18);
    idle();
    chk("t3_bubble_valid", {47'd0, ov_w}, 48'd0);
    chk("t3_bubble_p",     p_w, 48'd18);
    idle();
    chk("t3_p24",    p_w, 48'd24);
    chk("t3_valid4", {47'd0, ov_w}, 48'd1);

    // Overflow: (2^47-1) + 1 wraps or saturates
    send(18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 1'b0, 8'h04);
    idle(); idle();
    chk("t4_wrap_p",   p_w,   48'h8000_0000_0000);
    chk("t4_wrap_ovf", {47'd0, ovf_w}, 48'd1);
    chk("t4_sat_p",    p_s,   48'h7FFF_FFFF_FFFF);
    chk("t4_sat_ovf",  {47'd0, ovf_s}, 48'd1);
    // Reserved OPMODE bits set: 5 + 1*1 = 6, overflow clears
    send(18'd1, 18'd1, 18'd0, 48'd5, 1'b0, 8'hC4);
    idle(); idle();
    chk("t4_rsvd_p",   p_w, 48'd6);
    chk("t4_ovf_clr",  {47'd0, ovf_w}, 48'd0);
    chk("t4_sat_clr",  {47'd0, ovf_s}, 48'd0);
    // Z=PCIN: 100 + 1*2 = 102
    PCIN = 48'd100;
    send(18'd1, 18'd2, 18'd0, 48'd0, 1'b0, 8'h08);
    idle(); idle();
    chk("t4_pcin_p", p_w, 48'd102);

    // CE freeze with samples in flight: products 5, 10, 15
    send(18'd1, 18'd5, 18'd0, 48'd0, 1'b0, 8'h00);
    send(18'd2, 18'd5, 18'd0, 48'd0, 1'b0, 8'h00);
    send(18'd3, 18'd5, 18'd0, 48'd0, 1'b0, 8'h00);
    chk("t5_p5", p_w, 48'd5);
    CE = 1'b0;
    A = 18'd7; B = 18'd7; IN_VALID = 1'b1;
    tick(); tick();
    chk("t5_frz_p",     p_w, 48'd5);
    chk("t5_frz_m",     {11'd0, m_w}, 48'd10);
    chk("t5_frz_valid", {47'd0, ov_w}, 48'd1);
    chk("t5_frz_bc",    {30'd0, bc_w}, 48'd5);
    CE = 1'b1;
    idle();
    chk("t5_p10", p_w, 48'd10);
    idle();
    chk("t5_p15", p_w, 48'd15);
    idle();
    chk("t5_no_extra", {47'd0, ov_w}, 48'd0);

    // Reset mid-accumulation
    send(18'd2, 18'd3, 18'd0, 48'd0, 1'b0, 8'h00);
    send(18'd2, 18'd3, 18'd0, 48'd0, 1'b0, 8'h0C);
    send(18'd2, 18'd3, 18'd0, 48'd0, 1'b0, 8'h0C);
    chk("t6_pre_p", p_w, 48'd6);
    #2;
    RSTN = 1'b0;
    #1;
    chk("t6_async_p",     p_w, 48'd0);
    chk("t6_async_valid", {47'd0, ov_w}, 48'd0);
    chk("t6_async_m",     {11'd0, m_w}, 48'd0);
    IN_VALID = 1'b0;
    tick();
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t6_no_stale", {47'd0, ov_w}, 48'd0);
    end
    send(18'd4, 18'd4, 18'd0, 48'd0, 1'b0, 8'h00);
    idle();
    chk("t6_lat_e1", {47'd0, ov_w}, 48'd0);
    idle();
    chk("t6_lat_e2", {47'd0, ov_w}, 48'd1);
    chk("t6_p16",    p_w, 48'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
